// File: rtl/shift_reg_1.sv
// UART transmit frame shifter: loads an assembled 9..12-bit frame on an active-low
// send request and shifts it out LSB first, one bit per baud_out edge.
module shift_reg_1 (
  input  logic        baud_out,
  input  logic        rst,
  input  logic [11:0] frame_out,
  input  logic        data_lenth,
  input  logic [1:0]  parity_type,
  input  logic        stop_bits,
  input  logic        send,
  output logic        data_out,
  output logic        p_parity_out,
  output logic        tx_active,
  output logic        tx_done
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_TX   = 1'b1
  } state_e;

  // Handshake: send is a level request, sampled low on a rising edge only while
  // tx_active is low; tx_done pulses for the single idle cycle after each frame.

  state_e      state_q, state_d;
  logic [11:0] shift_q, shift_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  last_q, last_d;
  logic        data_q, data_d;
  logic        par_q, par_d;
  logic        act_q, act_d;
  logic        done_q, done_d;

  logic        par_en;
  logic [3:0]  last_idx;

  assign par_en   = (parity_type == 2'b01) || (parity_type == 2'b10);
  // Index of the final frame bit: N-1 = 8 + data_lenth + parity slot + extra stop bit.
  assign last_idx = 4'd8 + {3'b000, data_lenth} + {3'b000, par_en} + {3'b000, stop_bits};

  always_ff @(posedge baud_out or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      data_q  <= 1'b1;
      par_q   <= 1'b0;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      data_q  <= data_d;
      par_q   <= par_d;
      act_q   <= act_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    last_d  = last_q;
    data_d  = data_q;
    par_d   = par_q;
    act_d   = act_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        data_d = 1'b1;
        act_d  = 1'b0;
        if (!send) begin
          state_d = S_TX;
          shift_d = frame_out;
          idx_d   = 4'd0;
          last_d  = last_idx;
          data_d  = frame_out[0];
          act_d   = 1'b1;
          // The slot bit is forwarded as supplied; parity_type only sizes the frame.
          par_d   = par_en & (data_lenth ? frame_out[9] : frame_out[8]);
        end
      end
      S_TX: begin
        if (idx_q == last_q) begin
          state_d = S_IDLE;
          shift_d = '0;
          idx_d   = 4'd0;
          data_d  = 1'b1;
          act_d   = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 4'd1;
          shift_d = {1'b0, shift_q[11:1]};
          data_d  = shift_q[1];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign data_out     = data_q;
  assign p_parity_out = par_q;
  assign tx_active    = act_q;
  assign tx_done      = done_q;

endmodule

// File: tb/tb_shift_reg_1.sv
// Bench for shift_reg_1: directed frames from the test plan plus randomized frames,
// checked against a frame-length/parity model derived from the framing rules.
module tb_shift_reg_1;

  logic        baud_out;
  logic        rst;
  logic [11:0] frame_out;
  logic        data_lenth;
  logic [1:0]  parity_type;
  logic        stop_bits;
  logic        send;
  logic        data_out;
  logic        p_parity_out;
  logic        tx_active;
  logic        tx_done;

  int checks = 0;
  int errors = 0;

  shift_reg_1 dut (
    .baud_out     (baud_out),
    .rst          (rst),
    .frame_out    (frame_out),
    .data_lenth   (data_lenth),
    .parity_type  (parity_type),
    .stop_bits    (stop_bits),
    .send         (send),
    .data_out     (data_out),
    .p_parity_out (p_parity_out),
    .tx_active    (tx_active),
    .tx_done      (tx_done)
  );

  // clock / reset
  initial baud_out = 1'b0;
  always #5 baud_out = ~baud_out;

  // ---------------- reference model ----------------
  function automatic int model_len(input logic dl, input logic [1:0] pt, input logic sb);
    int n;
    n = 1 + (dl ? 8 : 7);
    if (pt == 2'b01 || pt == 2'b10) n = n + 1;
    n = n + (sb ? 2 : 1);
    return n;
  endfunction

  function automatic logic model_par(input logic [11:0] fr, input logic dl, input logic [1:0] pt);
    if (pt == 2'b01 || pt == 2'b10) return fr[dl ? 9 : 8];
    return 1'b0;
  endfunction

  // Advance one edge; outputs are sampled and inputs driven 1 time unit later.
  task automatic tick();
    @(posedge baud_out);
    #1;
  endtask

  // ---------------- driver: one frame with send held low for 'hold' edges ----------------
  task automatic run_frame(input logic [11:0] fr, input logic dl, input logic [1:0] pt,
                           input logic sb, input int hold, input string name);
    int   n;
    logic par;
    logic [11:0] exp_q[$];
    n   = model_len(dl, pt, sb);
    par = model_par(fr, dl, pt);
    for (int i = 0; i < n; i++) exp_q.push_back({11'd0, fr[i]});
    frame_out = fr; data_lenth = dl; parity_type = pt; stop_bits = sb; send = 1'b0;
    for (int i = 0; i < n; i++) begin
      logic exp_bit;
      tick();
      exp_bit = exp_q.pop_front() [0];
      checks++;
      if (data_out !== exp_bit || tx_active !== 1'b1 || tx_done !== 1'b0) begin
        errors++;
        $display("FAIL %s bit%0d: data_out=%b tx_active=%b tx_done=%b, required %b 1 0",
                 name, i, data_out, tx_active, tx_done, exp_bit);
      end
      checks++;
      if (p_parity_out !== par) begin
        errors++;
        $display("FAIL %s parity bit%0d: p_parity_out=%b, required %b", name, i, p_parity_out, par);
      end
      send = (i + 1 < hold) ? 1'b0 : 1'b1;
      // Inputs are scrambled mid-frame; they must not disturb the frame in flight.
      frame_out   = 12'($urandom);
      data_lenth  = 1'($urandom);
      parity_type = 2'($urandom);
      stop_bits   = 1'($urandom);
    end
    tick();
    checks++;
    if (data_out !== 1'b1 || tx_active !== 1'b0 || tx_done !== 1'b1) begin
      errors++;
      $display("FAIL %s end: data_out=%b tx_active=%b tx_done=%b, required 1 0 1",
               name, data_out, tx_active, tx_done);
    end
    send = 1'b1;
    tick();
    checks++;
    if (data_out !== 1'b1 || tx_active !== 1'b0 || tx_done !== 1'b0 || p_parity_out !== par) begin
      errors++;
      $display("FAIL %s after: data_out=%b tx_active=%b tx_done=%b parity=%b, required 1 0 0 %b",
               name, data_out, tx_active, tx_done, p_parity_out, par);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; send = 1'b0;
    frame_out = 12'hFFF; data_lenth = 1'b1; parity_type = 2'b01; stop_bits = 1'b1;
    repeat (3) tick();
    checks++;
    if (data_out !== 1'b1 || tx_active !== 1'b0 || tx_done !== 1'b0 || p_parity_out !== 1'b0) begin
      errors++;
      $display("FAIL reset: data_out=%b tx_active=%b tx_done=%b parity=%b, required 1 0 0 0",
               data_out, tx_active, tx_done, p_parity_out);
    end
    rst = 1'b1;
    run_frame(12'hE5A, 1'b0, 2'b00, 1'b0, 1, "reset_first_frame");
  endtask

  task automatic test_plan_frames();
    run_frame(12'hFAE, 1'b0, 2'b01, 1'b0, 1, "odd7");
    run_frame(12'hF12, 1'b0, 2'b10, 1'b0, 2, "even7_hold2");
    run_frame(12'h3FC, 1'b1, 2'b00, 1'b1, 1, "8n2");
    run_frame(12'h7FC, 1'b1, 2'b11, 1'b1, 1, "8n2_pt11");
    run_frame(12'h5FF, 1'b1, 2'b10, 1'b1, 1, "8e2_max");
  endtask

  task automatic test_back_to_back();
    logic [11:0] cur_fr, nxt_fr;
    logic        cur_dl, nxt_dl, cur_sb, nxt_sb;
    logic [1:0]  cur_pt, nxt_pt;
    int          n;
    logic        par;
    cur_fr = 12'($urandom); cur_dl = 1'($urandom); cur_pt = 2'($urandom); cur_sb = 1'($urandom);
    nxt_fr = cur_fr; nxt_dl = cur_dl; nxt_pt = cur_pt; nxt_sb = cur_sb;
    frame_out = cur_fr; data_lenth = cur_dl; parity_type = cur_pt; stop_bits = cur_sb;
    send = 1'b0;
    tick();
    for (int f = 0; f < 4; f++) begin
      n   = model_len(cur_dl, cur_pt, cur_sb);
      par = model_par(cur_fr, cur_dl, cur_pt);
      for (int i = 0; i < n; i++) begin
        checks++;
        if (data_out !== cur_fr[i] || tx_active !== 1'b1 || p_parity_out !== par) begin
          errors++;
          $display("FAIL b2b f%0d bit%0d: data_out=%b tx_active=%b parity=%b, required %b 1 %b",
                   f, i, data_out, tx_active, p_parity_out, cur_fr[i], par);
        end
        if (i == 2) begin
          nxt_fr = 12'($urandom); nxt_dl = 1'($urandom);
          nxt_pt = 2'($urandom);  nxt_sb = 1'($urandom);
          frame_out = nxt_fr; data_lenth = nxt_dl; parity_type = nxt_pt; stop_bits = nxt_sb;
        end
        tick();
      end
      checks++;
      if (data_out !== 1'b1 || tx_active !== 1'b0 || tx_done !== 1'b1) begin
        errors++;
        $display("FAIL b2b f%0d gap: data_out=%b tx_active=%b tx_done=%b, required 1 0 1",
                 f, data_out, tx_active, tx_done);
      end
      if (f == 3) send = 1'b1;
      tick();
      cur_fr = nxt_fr; cur_dl = nxt_dl; cur_pt = nxt_pt; cur_sb = nxt_sb;
    end
    checks++;
    if (data_out !== 1'b1 || tx_active !== 1'b0 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b stop: data_out=%b tx_active=%b tx_done=%b, required 1 0 0",
               data_out, tx_active, tx_done);
    end
  endtask

  task automatic test_reset_mid_frame();
    frame_out = 12'hFAE; data_lenth = 1'b0; parity_type = 2'b01; stop_bits = 1'b0; send = 1'b0;
    tick();
    send = 1'b1;
    repeat (4) tick();
    checks++;
    if (data_out !== 1'b0 || tx_active !== 1'b1) begin
      errors++;
      $display("FAIL midrst bit4: data_out=%b tx_active=%b, required 0 1", data_out, tx_active);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (data_out !== 1'b1 || tx_active !== 1'b0 || tx_done !== 1'b0 || p_parity_out !== 1'b0) begin
      errors++;
      $display("FAIL midrst async: data_out=%b tx_active=%b tx_done=%b parity=%b, required 1 0 0 0",
               data_out, tx_active, tx_done, p_parity_out);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (data_out !== 1'b1 || tx_active !== 1'b0 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL midrst idle: data_out=%b tx_active=%b tx_done=%b, required 1 0 0",
               data_out, tx_active, tx_done);
    end
    run_frame(12'hA53, 1'b1, 2'b01, 1'b0, 1, "midrst_restart");
  endtask

  task automatic test_random();
    for (int k = 0; k < 25; k++) begin
      run_frame(12'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                $urandom_range(1, 2), "random");
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    send = 1'b1; rst = 1'b0;
    frame_out = '0; data_lenth = 1'b0; parity_type = 2'b00; stop_bits = 1'b0;
    test_reset();
    test_plan_frames();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
